rf_link_master: RTL

//  Host-side master for the byte-serial register-file link (one 8-bit shift-in lane, store/load/shift

---
 rtl/rf_link_master_if.sv | 38 +++
 rtl/rf_link_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rf_link_master_if.sv
// rf_link_master_if
//   Bundles the command/response handshake and the byte-serial link pins
//   of the register-file link master.
//   master modport (seen from rf_link_master):
//     in : cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, link_byte_in
//     out: cmd_ready, rsp_valid, rsp_rdata, link_byte_out, link_shift,
//          link_load, link_store
//   slave modport: the same signals with directions reversed (host + target).
interface rf_link_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [7:0]        link_byte_out;
  logic              link_shift;
  logic              link_load;
  logic              link_store;
  logic [7:0]        link_byte_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, link_byte_in,
    output cmd_ready, rsp_valid, rsp_rdata, link_byte_out, link_shift,
           link_load, link_store
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, link_byte_in,
    input  cmd_ready, rsp_valid, rsp_rdata, link_byte_out, link_shift,
           link_load, link_store
  );
endinterface

// File: rtl/rf_link_master.sv
// rf_link_master
//   Host-side master for the byte-serial register-file link. One accepted
//   read/write command becomes a frame of NB bytes shifted MSB byte first,
//   followed by a store strobe (write) or a load strobe plus NR read-back
//   samples (read), and finally a held response.
//   Ports:
//     clk    - clock
//     rst_n  - synchronous active-low reset
//     bus    - rf_link_master_if.master: command/response handshake and the
//              link pins (byte out, shift/load/store strobes, byte in)
//   Parameters: ADDR_W, DATA_W, GAP (idle cycles after every strobe, 0..15).
module rf_link_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int GAP    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  rf_link_master_if.master bus
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int NB      = (FRAME_W + 7) / 8;
  localparam int NR      = DATA_W / 8;
  localparam int BUF_W   = NB * 8;
  localparam int CNT_MAX = (NB > NR) ? NB : NR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0]       GAP_L   = 4'(GAP);
  // A read sample sits in the last idle cycle before the next strobe, so
  // the wait in front of a sample is one shorter than the full gap.
  localparam logic [3:0]       GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [CNT_W-1:0] NB_LAST = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] NR_LAST = CNT_W'(NR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_STORE,
    S_LOAD,
    S_READ,
    S_RSHIFT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_sel;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [7:0]         byte_out_q, byte_out_d;
  logic               shift_q, shift_d;
  logic               load_q, load_d;
  logic               store_q, store_d;

  // state_q names the phase of the current cycle; while wait_q is non-zero
  // the cycle is a strobe-free gap cycle of that phase. All pin outputs are
  // registered, so they are decoded from the *next* phase (state_d/wait_d).
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    wdata_sel = bus.cmd_write ? bus.cmd_wdata : '0;

    if (wait_q != 4'd0) begin
      wait_d = wait_q - 4'd1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            write_d                = bus.cmd_write;
            frame_d                = '0;
            frame_d[FRAME_W-1:0]   = {wdata_sel, bus.cmd_addr};
            rdata_d                = '0;
            cnt_d                  = '0;
            state_d                = S_SHIFT;
          end
        end
        S_SHIFT: begin
          frame_d = frame_q << 8;
          wait_d  = GAP_L;
          if (cnt_q == NB_LAST) begin
            cnt_d   = '0;
            state_d = write_q ? S_STORE : S_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STORE: begin
          wait_d  = GAP_L;
          state_d = S_RESP;
        end
        S_LOAD: begin
          wait_d  = GAP_M1;
          cnt_d   = '0;
          state_d = S_READ;
        end
        // Sample cycle. With GAP=0 the read-back shift shares this cycle,
        // otherwise it gets its own S_RSHIFT cycle right after.
        S_READ: begin
          rdata_d = {rdata_q[DATA_W-9:0], bus.link_byte_in};
          if (cnt_q == NR_LAST) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (GAP == 0) begin
              state_d = S_READ;
            end else begin
              state_d = S_RSHIFT;
            end
          end
        end
        S_RSHIFT: begin
          wait_d  = GAP_M1;
          state_d = S_READ;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP) && (wait_d == 4'd0);
    store_d     = (state_d == S_STORE) && (wait_d == 4'd0);
    load_d      = (state_d == S_LOAD) && (wait_d == 4'd0);
    shift_d     = (wait_d == 4'd0) &&
                  ((state_d == S_SHIFT) || (state_d == S_RSHIFT) ||
                   ((GAP == 0) && (state_d == S_READ) && (cnt_d != NR_LAST)));
    // Read-back shifts push zero bytes; only frame shifts carry data.
    byte_out_d  = (shift_d && (state_d == S_SHIFT)) ? frame_d[BUF_W-1 -: 8] : 8'h00;
    rsp_rdata_d = rsp_valid_d ? rdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 4'd0;
      cnt_q       <= '0;
      frame_q     <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      byte_out_q  <= 8'h00;
      shift_q     <= 1'b0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      rdata_q     <= rdata_d;
      write_q     <= write_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      byte_out_q  <= byte_out_d;
      shift_q     <= shift_d;
      load_q      <= load_d;
      store_q     <= store_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.link_byte_out = byte_out_q;
  assign bus.link_shift    = shift_q;
  assign bus.link_load     = load_q;
  assign bus.link_store    = store_q;

endmodule
